// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared encodings for the multi-cycle controller: FSM states,
//             opcode/funct values, ALU codes, select encodings and the
//             instruction class produced by the decoder.
//  Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes (inst[5:0]); ALU functions share these values
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_SLT = 6'h2a;

  // Select encodings
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic       ADDR_PC   = 1'b0;
  localparam logic       ADDR_ALU  = 1'b1;
  localparam logic       OPA_RS    = 1'b0;
  localparam logic       OPA_SHAMT = 1'b1;
  localparam logic [1:0] OPB_RT    = 2'd0;
  localparam logic [1:0] OPB_IMM   = 2'd1;
  localparam logic [1:0] DEST_RT   = 2'd0;
  localparam logic [1:0] DEST_RD   = 2'd1;
  localparam logic [1:0] DEST_RA   = 2'd2;
  localparam logic [1:0] DATA_ALU  = 2'd0;
  localparam logic [1:0] DATA_MEM  = 2'd1;
  localparam logic [1:0] DATA_PC   = 2'd2;

  // Instruction classes seen by the FSM
  typedef enum logic [3:0] {
    CL_NONE, CL_RALU, CL_ADDI, CL_SLTI, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR
  } inst_class_e;

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_if
//  Purpose  : Controller <-> datapath/memory bundle. master = controller,
//             slave = datapath side.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_if;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        sel_addr;
  logic        ir_wr;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        sel_opA;
  logic [1:0]  sel_opB;
  logic [1:0]  sel_dest;
  logic [1:0]  sel_data;
  logic [5:0]  alu_op;
  logic        wr_en;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  inst, zero, mem_ack,
    output mem_req, mem_we, sel_addr, ir_wr, pc_wr, pc_src, sel_opA, sel_opB,
           sel_dest, sel_data, alu_op, wr_en, illegal, instret
  );

  modport slave (
    output inst, zero, mem_ack,
    input  mem_req, mem_we, sel_addr, ir_wr, pc_wr, pc_src, sel_opA, sel_opB,
           sel_dest, sel_data, alu_op, wr_en, illegal, instret
  );
endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Purely combinational classifier: opcode/funct -> instruction
//             class, legal flag, and shift flag (shamt as ALU A operand).
//  Revision : 1.0  initial release
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output inst_class_e o_class,
  output logic        o_legal,
  output logic        o_shift
);

  // Map opcode (and funct for R-type) onto a class; anything else is CL_NONE
  always_comb begin
    o_class = CL_NONE;
    o_shift = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_SUB, FN_SLT: o_class = CL_RALU;
          FN_SLL, FN_SRL: begin
            o_class = CL_RALU;
            o_shift = 1'b1;
          end
          FN_JR:   o_class = CL_JR;
          default: o_class = CL_NONE;
        endcase
      end
      OP_ADDI: o_class = CL_ADDI;
      OP_SLTI: o_class = CL_SLTI;
      OP_LW:   o_class = CL_LW;
      OP_SW:   o_class = CL_SW;
      OP_BEQ:  o_class = CL_BEQ;
      OP_BNE:  o_class = CL_BNE;
      OP_J:    o_class = CL_J;
      OP_JAL:  o_class = CL_JAL;
      default: o_class = CL_NONE;
    endcase
  end

  assign o_legal = (o_class != CL_NONE);

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller. All strobes
//             and selects are combinational from state, inst, zero and
//             mem_ack; reset forces every output low.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mc_if.master bus
);

  logic [2:0]  r_state;
  logic [31:0] r_instret;

  logic [2:0]  w_next;
  logic        w_retire;
  logic        w_mem_req, w_mem_we, w_sel_addr, w_ir_wr, w_pc_wr;
  logic [1:0]  w_pc_src;
  logic        w_sel_opA;
  logic [1:0]  w_sel_opB, w_sel_dest, w_sel_data;
  logic [5:0]  w_alu_op;
  logic        w_wr_en, w_illegal;

  inst_class_e w_class;
  logic        w_legal;
  logic        w_shift;

  mc_decode u_decode (
    .i_opcode (bus.inst[31:26]),
    .i_funct  (bus.inst[5:0]),
    .o_class  (w_class),
    .o_legal  (w_legal),
    .o_shift  (w_shift)
  );

  // Next-state, retire and output decode for the current state
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_sel_addr = ADDR_PC;
    w_ir_wr    = 1'b0;
    w_pc_wr    = 1'b0;
    w_pc_src   = PC_PLUS4;
    w_sel_opA  = OPA_RS;
    w_sel_opB  = OPB_RT;
    w_sel_dest = DEST_RT;
    w_sel_data = DATA_ALU;
    w_alu_op   = 6'h00;
    w_wr_en    = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          w_ir_wr = 1'b1;
          w_pc_wr = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
          w_illegal = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        case (w_class)
          CL_RALU: begin
            // R-type ALU ops pass funct straight through as the ALU code
            w_alu_op  = bus.inst[5:0];
            w_sel_opA = w_shift ? OPA_SHAMT : OPA_RS;
            w_next    = ST_WB;
          end
          CL_ADDI: begin
            w_alu_op  = ALU_ADD;
            w_sel_opB = OPB_IMM;
            w_next    = ST_WB;
          end
          CL_SLTI: begin
            w_alu_op  = ALU_SLT;
            w_sel_opB = OPB_IMM;
            w_next    = ST_WB;
          end
          CL_LW, CL_SW: begin
            w_alu_op  = ALU_ADD;
            w_sel_opB = OPB_IMM;
            w_next    = ST_MEM;
          end
          CL_BEQ, CL_BNE: begin
            w_alu_op = ALU_SUB;
            w_retire = 1'b1;
            // BEQ takes on zero, BNE on not-zero
            if ((w_class == CL_BEQ) == bus.zero) begin
              w_pc_wr  = 1'b1;
              w_pc_src = PC_BRANCH;
            end
          end
          CL_J: begin
            w_pc_wr  = 1'b1;
            w_pc_src = PC_JUMP;
            w_retire = 1'b1;
          end
          CL_JAL: begin
            w_pc_wr    = 1'b1;
            w_pc_src   = PC_JUMP;
            w_wr_en    = 1'b1;
            w_sel_dest = DEST_RA;
            w_sel_data = DATA_PC;
            w_retire   = 1'b1;
          end
          CL_JR: begin
            w_pc_wr  = 1'b1;
            w_pc_src = PC_RS;
            w_retire = 1'b1;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_mem_req  = 1'b1;
        w_sel_addr = ADDR_ALU;
        w_mem_we   = (w_class == CL_SW);
        if (bus.mem_ack) begin
          if (w_class == CL_SW) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_wr_en    = 1'b1;
        w_sel_dest = (w_class == CL_RALU) ? DEST_RD : DEST_RT;
        w_sel_data = (w_class == CL_LW) ? DATA_MEM : DATA_ALU;
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // Reset masks every output, so an abandoned access issues no strobe
  assign bus.mem_req  = w_mem_req  & ~rst;
  assign bus.mem_we   = w_mem_we   & ~rst;
  assign bus.sel_addr = w_sel_addr & ~rst;
  assign bus.ir_wr    = w_ir_wr    & ~rst;
  assign bus.pc_wr    = w_pc_wr    & ~rst;
  assign bus.pc_src   = rst ? 2'd0 : w_pc_src;
  assign bus.sel_opA  = w_sel_opA  & ~rst;
  assign bus.sel_opB  = rst ? 2'd0 : w_sel_opB;
  assign bus.sel_dest = rst ? 2'd0 : w_sel_dest;
  assign bus.sel_data = rst ? 2'd0 : w_sel_data;
  assign bus.alu_op   = rst ? 6'd0 : w_alu_op;
  assign bus.wr_en    = w_wr_en    & ~rst;
  assign bus.illegal  = w_illegal  & ~rst;
  assign bus.instret  = rst ? 32'd0 : r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Directed self-checking bench for mc_control. Each step drives
//             mem_ack/zero, compares the packed output vector, then clocks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mc_if bus ();

  mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {mem_req,mem_we,sel_addr,ir_wr,pc_wr,pc_src,sel_opA,
  //               sel_opB,sel_dest,sel_data,alu_op,wr_en,illegal}
  logic [21:0] w_obs;
  assign w_obs = {bus.mem_req, bus.mem_we, bus.sel_addr, bus.ir_wr, bus.pc_wr,
                  bus.pc_src, bus.sel_opA, bus.sel_opB, bus.sel_dest,
                  bus.sel_data, bus.alu_op, bus.wr_en, bus.illegal};

  function automatic logic [21:0] ev(
    input logic mr, input logic mw, input logic sa, input logic ir,
    input logic pw, input logic [1:0] ps, input logic oa, input logic [1:0] ob,
    input logic [1:0] sd, input logic [1:0] sdat, input logic [5:0] alu,
    input logic we, input logic il);
    return {mr, mw, sa, ir, pw, ps, oa, ob, sd, sdat, alu, we, il};
  endfunction

  task automatic chk_out(input string tag, input logic [21:0] exp);
    total++;
    assert (w_obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    total++;
    assert (bus.instret === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.instret, exp);
    end
  endtask

  // Drive inputs, let combinational outputs settle, compare, then clock
  task automatic step(input logic ack, input logic z, input string tag,
                      input logic [21:0] exp);
    bus.mem_ack = ack;
    bus.zero    = z;
    #1;
    chk_out(tag, exp);
    @(posedge clk);
    #2;
  endtask

  logic [21:0] FW, FA, NONE;

  initial begin
    total = 0;
    bad   = 0;
    FW    = ev(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0);
    FA    = ev(1,0,0,1,1,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0);
    NONE  = 22'h0;

    rst = 1'b1;
    bus.inst = 32'h0;
    bus.mem_ack = 1'b1;
    bus.zero = 1'b0;
    @(posedge clk);
    #2;
    #1;
    chk_out("rst_outputs", NONE);
    chk_cnt("rst_instret", 32'd0);
    rst = 1'b0;

    // ADD $3,$1,$2 with zero-wait memory
    bus.inst = 32'h00221820;
    step(1, 0, "add_fetch", FA);
    step(1, 0, "add_decode", NONE);
    step(1, 0, "add_exec", ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h20,0,0));
    step(1, 0, "add_wb", ev(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd0,6'h00,1,0));
    chk_cnt("add_instret", 32'd1);

    // SLL $2,$2,2 : shamt on ALU A
    bus.inst = 32'h00021080;
    step(1, 0, "sll_fetch", FA);
    step(1, 0, "sll_decode", NONE);
    step(1, 0, "sll_exec", ev(0,0,0,0,0,2'd0,1,2'd0,2'd0,2'd0,6'h00,0,0));
    step(1, 0, "sll_wb", ev(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd0,6'h00,1,0));
    chk_cnt("sll_instret", 32'd2);

    // LW with two wait cycles in FETCH and in MEM: 9 cycles
    bus.inst = 32'h8C220004;
    step(0, 0, "lw_fetch_w0", FW);
    step(0, 0, "lw_fetch_w1", FW);
    step(1, 0, "lw_fetch_ack", FA);
    step(0, 0, "lw_decode", NONE);
    step(0, 0, "lw_exec", ev(0,0,0,0,0,2'd0,0,2'd1,2'd0,2'd0,6'h20,0,0));
    step(0, 0, "lw_mem_w0", ev(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0));
    step(0, 0, "lw_mem_w1", ev(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0));
    step(1, 0, "lw_mem_ack", ev(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0));
    chk_cnt("lw_instret_pre_wb", 32'd2);
    step(0, 0, "lw_wb", ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd1,6'h00,1,0));
    chk_cnt("lw_instret", 32'd3);

    // BEQ with zero=0: not taken, still retires
    bus.inst = 32'h10220003;
    step(1, 0, "beq_fetch", FA);
    step(1, 0, "beq_decode", NONE);
    step(1, 0, "beq_exec", ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h22,0,0));
    chk_cnt("beq_instret", 32'd4);

    // BNE with zero=0: taken
    bus.inst = 32'h14220003;
    step(1, 0, "bne_fetch", FA);
    step(1, 0, "bne_decode", NONE);
    step(1, 0, "bne_exec", ev(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd0,6'h22,0,0));
    chk_cnt("bne_instret", 32'd5);

    // JAL: jump and link in one cycle
    bus.inst = 32'h0C000010;
    step(1, 0, "jal_fetch", FA);
    step(1, 0, "jal_decode", NONE);
    step(1, 0, "jal_exec", ev(0,0,0,0,1,2'd2,0,2'd0,2'd2,2'd2,6'h00,1,0));
    chk_cnt("jal_instret", 32'd6);

    // JR $31
    bus.inst = 32'h03E00008;
    step(1, 0, "jr_fetch", FA);
    step(1, 0, "jr_decode", NONE);
    step(1, 1, "jr_exec", ev(0,0,0,0,1,2'd3,0,2'd0,2'd0,2'd0,6'h00,0,0));
    chk_cnt("jr_instret", 32'd7);

    // SW: 4 cycles, retires on MEM ack
    bus.inst = 32'hAC220004;
    step(1, 0, "sw_fetch", FA);
    step(1, 0, "sw_decode", NONE);
    step(1, 0, "sw_exec", ev(0,0,0,0,0,2'd0,0,2'd1,2'd0,2'd0,6'h20,0,0));
    step(1, 0, "sw_mem", ev(1,1,1,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,0));
    chk_cnt("sw_instret", 32'd8);

    // Illegal opcode 0x3F: one pulse, no retire, back to FETCH
    bus.inst = 32'hFC000000;
    step(1, 0, "ill_fetch", FA);
    step(1, 0, "ill_decode", ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,6'h00,0,1));
    step(0, 0, "ill_refetch", FW);
    chk_cnt("ill_instret", 32'd8);

    // Reset in MEM of SW while mem_ack=1: abandoned, no strobes
    bus.inst = 32'hAC220004;
    step(1, 0, "swr_fetch", FA);
    step(1, 0, "swr_decode", NONE);
    step(1, 0, "swr_exec", ev(0,0,0,0,0,2'd0,0,2'd1,2'd0,2'd0,6'h20,0,0));
    rst = 1'b1;
    step(1, 0, "swr_mem_rst", NONE);
    rst = 1'b0;
    chk_cnt("swr_instret", 32'd0);
    step(0, 0, "swr_refetch", FW);

    // Counter wrap: preload all-ones, retire a J
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    bus.inst = 32'h08000010;
    step(1, 0, "j_fetch", FA);
    step(1, 0, "j_decode", NONE);
    step(1, 0, "j_exec", ev(0,0,0,0,1,2'd2,0,2'd0,2'd0,2'd0,6'h00,0,0));
    chk_cnt("wrap_instret", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
